// File: rtl/cv32e41p_mult_seq.sv
// Iterative signed/unsigned multiplier with low-word MAC, retiring STEP_BITS
// multiplier bits per cycle and stopping early once the remaining multiplier is zero.
//
// state | meaning
// IDLE  | waiting for enable_i; operands captured on start
// ITER  | accumulating partial products, STEP_BITS per cycle
// DONE  | result_o valid, held until ex_ready_i or kill_i
module cv32e41p_mult_seq #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic [1:0]       op_i,
  input  logic             mac_i,
  input  logic             kill_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] op_c_i,
  input  logic             ex_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ready_o,
  output logic             multicycle_o
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               state;
  logic                 sign;
  logic                 mac_q;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     c_q;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;

  logic                 start;
  logic                 sa, sb;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     mplier_next;
  logic [2*WIDTH-1:0]   step_add;
  logic [2*WIDTH-1:0]   final_p;

  always_comb begin
    start       = enable_i && !kill_i;
    sa          = (op_i == 2'b01) || (op_i == 2'b10);
    sb          = (op_i == 2'b01);
    // Negating the most negative value wraps back to 2^(W-1), which is its true magnitude.
    a_mag       = (sa && op_a_i[WIDTH-1]) ? -op_a_i : op_a_i;
    b_mag       = (sb && op_b_i[WIDTH-1]) ? -op_b_i : op_b_i;
    mplier_next = mplier >> STEP_BITS;
    // mcand is pre-shifted each cycle, so it already carries the k*STEP_BITS weight.
    step_add    = mcand * {{(2*WIDTH-STEP_BITS){1'b0}}, mplier[STEP_BITS-1:0]};
    final_p     = sign ? -acc : acc;
  end

  always_comb begin
    result_o = '0;
    if (state == DONE) begin
      if (op_q == 2'b00) result_o = final_p[WIDTH-1:0] + (mac_q ? c_q : '0);
      else               result_o = final_p[2*WIDTH-1:WIDTH];
    end
    ready_o      = ((state == IDLE) && !enable_i) || (state == DONE);
    multicycle_o = (state == ITER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mac_q  <= 1'b0;
      op_q   <= 2'b00;
      c_q    <= '0;
      mplier <= '0;
      mcand  <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ITER;
            sign   <= (sa & op_a_i[WIDTH-1]) ^ (sb & op_b_i[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            c_q    <= op_c_i;
            op_q   <= op_i;
            mac_q  <= mac_i && (op_i == 2'b00);
          end
        end
        ITER: begin
          if (kill_i) begin
            state <= IDLE;
            acc   <= '0;
          end else begin
            acc    <= acc + step_add;
            mcand  <= mcand << STEP_BITS;
            mplier <= mplier_next;
            // The multiplier is W bits wide, so it is always empty after W/STEP_BITS shifts.
            if (mplier_next == '0) state <= DONE;
          end
        end
        DONE: begin
          if (kill_i) begin
            state <= IDLE;
            acc   <= '0;
          end else if (ex_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e41p_mult_seq.sv
// Self-checking bench for cv32e41p_mult_seq: directed cases with literal results,
// then random traffic checked every cycle against a plain-arithmetic model.
module tb_cv32e41p_mult_seq;

  localparam int W = 32;
  localparam int S = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic          mac_i = 1'b0;
  logic          kill_i = 1'b0;
  logic [W-1:0]  op_a_i = '0, op_b_i = '0, op_c_i = '0;
  logic          ex_ready_i = 1'b0;
  logic [W-1:0]  result_o;
  logic          ready_o;
  logic          multicycle_o;

  int errors = 0;
  int checks = 0;

  int           m_busy = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_res = '0;

  cv32e41p_mult_seq #(.WIDTH(W), .STEP_BITS(S)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .op_i(op_i), .mac_i(mac_i),
    .kill_i(kill_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i),
    .ex_ready_i(ex_ready_i), .result_o(result_o), .ready_o(ready_o),
    .multicycle_o(multicycle_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic [W-1:0] c,
                                                input logic mac);
    logic [2*W-1:0] ax, bx, prod;
    ax = (op == 2'b01 || op == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    bx = (op == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    prod = ax * bx;
    if (op == 2'b00) return prod[W-1:0] + (mac ? c : '0);
    return prod[2*W-1:W];
  endfunction

  function automatic int model_iters(input logic [1:0] op, input logic [W-1:0] b);
    logic [W-1:0] mag;
    int n;
    mag = (op == 2'b01 && b[W-1]) ? -b : b;
    n = 1;
    while (n < W / S && (mag >> (S * n)) != '0) n++;
    return n;
  endfunction

  // Reference transaction model, advanced on each active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_done = 1'b0;
      m_res  = '0;
    end else if (m_done) begin
      if (kill_i || ex_ready_i) m_done = 1'b0;
    end else if (m_busy > 0) begin
      if (kill_i) m_busy = 0;
      else begin
        m_busy--;
        if (m_busy == 0) m_done = 1'b1;
      end
    end else if (enable_i && !kill_i) begin
      m_res  = model_result(op_i, op_a_i, op_b_i, op_c_i, mac_i);
      m_busy = model_iters(op_i, op_b_i);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("multicycle", multicycle_o, m_busy > 0);
      chk("ready", ready_o, m_done || (m_busy == 0 && !enable_i));
      chk("result", result_o, m_done ? m_res : '0);
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input logic mac,
                        input int hold, input logic [W-1:0] lit, input int lit_iters);
    int iters;
    @(negedge clk);
    op_i = op; op_a_i = a; op_b_i = b; op_c_i = c; mac_i = mac;
    enable_i = 1'b1; ex_ready_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b0;
    op_a_i = $urandom; op_b_i = $urandom; op_c_i = $urandom; mac_i = ~mac;
    iters = 0;
    for (int i = 0; i < 20 && multicycle_o; i++) begin
      iters++;
      @(negedge clk);
    end
    if (multicycle_o) begin
      errors++;
      $display("FAIL %s_timeout: multicycle_o still high after 20 cycles", name);
    end
    chk({name, "_iters"}, iters, lit_iters);
    chk({name, "_res"}, result_o, lit);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({name, "_hold_res"}, result_o, lit);
      chk({name, "_hold_rdy"}, ready_o, 1'b1);
    end
    ex_ready_i = 1'b1;
    @(negedge clk);
    ex_ready_i = 1'b0;
    chk({name, "_idle_res"}, result_o, 0);
    chk({name, "_idle_mc"}, multicycle_o, 1'b0);
  endtask

  initial begin
    #1;
    chk("rst_result", result_o, 0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_multicycle", multicycle_o, 1'b0);
    chk("model_mulhu", model_result(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0), 32'hFFFFFFFE);
    chk("model_iters0", model_iters(2'b00, 32'h0), 1);
    chk("model_iters_mulh", model_iters(2'b01, 32'h80000000), 4);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("mulhu_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 0, 32'hFFFFFFFE, 4);
    run_op("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 0, 1'b0, 0, 32'h40000000, 4);
    run_op("mul_min", 2'b00, 32'h80000000, 32'h80000000, 0, 1'b0, 0, 32'h00000000, 4);
    run_op("mulhsu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 0, 32'hFFFFFFFF, 4);
    run_op("mac", 2'b00, 32'd7, 32'd3, 32'd100, 1'b1, 0, 32'd121, 1);
    run_op("mac_ignored", 2'b01, 32'd7, 32'd3, 32'd100, 1'b1, 0, 32'd0, 1);
    run_op("b_zero_mac", 2'b00, 32'h12345678, 32'd0, 32'd55, 1'b1, 0, 32'd55, 1);
    run_op("hold3", 2'b00, 32'd1000, 32'h1234, 0, 1'b0, 3, 32'd4660000, 2);

    // kill in the second ITER cycle
    @(negedge clk);
    op_i = 2'b11; op_a_i = 32'hFFFFFFFF; op_b_i = 32'hFFFFFFFF; mac_i = 1'b0; enable_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b0;
    @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill_ready", ready_o, 1'b1);
    chk("kill_result", result_o, 0);
    chk("kill_mc", multicycle_o, 1'b0);

    // asynchronous reset mid-ITER
    @(negedge clk);
    op_i = 2'b00; enable_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b0;
    chk("prerst_mc", multicycle_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_mc", multicycle_o, 1'b0);
    chk("arst_ready", ready_o, 1'b1);
    chk("arst_result", result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 2'b00, 32'd5, 32'd6, 0, 1'b0, 0, 32'd30, 1);

    // random traffic, checked each cycle by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      enable_i   = 1'($urandom_range(0, 1));
      kill_i     = ($urandom_range(0, 19) == 0);
      ex_ready_i = ($urandom_range(0, 3) != 0);
      op_i       = 2'($urandom_range(0, 3));
      mac_i      = 1'($urandom_range(0, 1));
      op_a_i     = $urandom;
      op_b_i     = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) op_b_i = -op_b_i;
      op_c_i     = $urandom;
    end
    @(negedge clk);
    enable_i = 1'b0; kill_i = 1'b0; ex_ready_i = 1'b1;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
